// File: rtl/flag_branch_unit_if.sv
// Upstream/downstream handshake bundle for the execute-stage flag/branch back end.
// The master side is whoever feeds packets in and drains writebacks; slave is the unit.
interface flag_branch_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [2:0]  alu_flag;
  logic        flag_we;
  logic [2:0]  br_type;
  logic [31:0] br_target;
  logic [31:0] pc_plus4;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic        branch_taken;
  logic [31:0] next_pc;
  logic [2:0]  flags_q;

  modport master (
    output in_valid, alu_result, alu_flag, flag_we, br_type, br_target,
           pc_plus4, rd_addr, rd_we, out_ready,
    input  in_ready, out_valid, wb_data, wb_addr, wb_en, branch_taken,
           next_pc, flags_q
  );

  modport slave (
    input  in_valid, alu_result, alu_flag, flag_we, br_type, br_target,
           pc_plus4, rd_addr, rd_we, out_ready,
    output in_ready, out_valid, wb_data, wb_addr, wb_en, branch_taken,
           next_pc, flags_q
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Execute-stage back end: architectural flags, branch resolution, wrong-path squash
// and a single registered writeback entry behind a valid/ready handshake.
module flag_branch_unit #(
  parameter int FLUSH_SLOTS = 1,
  parameter int LINK_REG    = 31
) (
  input  logic               clk,
  input  logic               rst,
  flag_branch_unit_if.slave  bus
);

  typedef enum logic {RUN, SQUASH} state_e;

  localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_SLOTS);
  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_B    = 3'b001;
  localparam logic [2:0] BR_LTZ  = 3'b010;
  localparam logic [2:0] BR_Z    = 3'b011;
  localparam logic [2:0] BR_NZ   = 3'b100;
  localparam logic [2:0] BR_CY   = 3'b101;
  localparam logic [2:0] BR_NCY  = 3'b110;
  localparam logic [2:0] BR_L    = 3'b111;

  state_e      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        accept;
  logic        live;
  logic        taken;
  logic [31:0] wb_data_d;
  logic [4:0]  wb_addr_d;
  logic        wb_en_d;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign live         = accept && (state == RUN);

  // Carry branches look at the held flags, not the incoming op's flags.
  always_comb begin
    taken = 1'b0;
    case (bus.br_type)
      BR_NONE: taken = 1'b0;
      BR_B:    taken = 1'b1;
      BR_LTZ:  taken = bus.alu_flag[2];
      BR_Z:    taken = bus.alu_flag[1];
      BR_NZ:   taken = !bus.alu_flag[1];
      BR_CY:   taken = bus.flags_q[0];
      BR_NCY:  taken = !bus.flags_q[0];
      BR_L:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_data_d = bus.alu_result;
    wb_addr_d = bus.rd_addr;
    wb_en_d   = bus.rd_we && (bus.rd_addr != 5'd0);
    if (bus.br_type == BR_L) begin
      wb_data_d = bus.pc_plus4;
      wb_addr_d = LINK_ADDR;
      wb_en_d   = (LINK_ADDR != 5'd0);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (live && taken && (FLUSH_CNT != 3'd0)) begin
          state_nx = SQUASH;
          cnt_nx   = FLUSH_CNT;
        end
      end
      SQUASH: begin
        if (accept) begin
          cnt_nx = cnt - 3'd1;
          if (cnt == 3'd1) state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Squashed accepts still free the entry if the consumer drained it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.wb_data      <= 32'd0;
      bus.wb_addr      <= 5'd0;
      bus.wb_en        <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.next_pc      <= 32'd0;
      bus.flags_q      <= 3'b000;
    end else if (live) begin
      bus.out_valid    <= 1'b1;
      bus.wb_data      <= wb_data_d;
      bus.wb_addr      <= wb_addr_d;
      bus.wb_en        <= wb_en_d;
      bus.branch_taken <= taken;
      bus.next_pc      <= taken ? bus.br_target : bus.pc_plus4;
      if (bus.flag_we) bus.flags_q <= bus.alu_flag;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: a reference model predicts each writeback
// packet at accept time and the scenario tasks compare it when the DUT presents it.
module tb_flag_branch_unit;

  localparam int FLUSH = 1;
  localparam int LINK  = 31;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [70:0] sb[$];
  logic [2:0]  model_flags;
  int          model_squash;

  flag_branch_unit_if bus();

  flag_branch_unit #(.FLUSH_SLOTS(FLUSH), .LINK_REG(LINK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wire [70:0] pkt = {bus.wb_data, bus.wb_addr, bus.wb_en, bus.branch_taken, bus.next_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model step for one accept, using whatever the bench is driving.
  task automatic model_accept(output logic live);
    logic        tk;
    logic [31:0] d;
    logic [4:0]  a;
    logic        e;
    live = 1'b0;
    if (model_squash > 0) begin
      model_squash--;
    end else begin
      live = 1'b1;
      case (bus.br_type)
        3'd0: tk = 1'b0;
        3'd1: tk = 1'b1;
        3'd2: tk = bus.alu_flag[2];
        3'd3: tk = bus.alu_flag[1];
        3'd4: tk = ~bus.alu_flag[1];
        3'd5: tk = model_flags[0];
        3'd6: tk = ~model_flags[0];
        default: tk = 1'b1;
      endcase
      if (bus.br_type == 3'd7) begin
        d = bus.pc_plus4; a = 5'(LINK); e = 1'b1;
      end else begin
        d = bus.alu_result; a = bus.rd_addr; e = bus.rd_we && (bus.rd_addr != 5'd0);
      end
      sb.push_back({d, a, e, tk, tk ? bus.br_target : bus.pc_plus4});
      if (bus.flag_we) model_flags = bus.alu_flag;
      if (tk && FLUSH > 0) model_squash = FLUSH;
    end
  endtask

  task automatic set_inputs(input logic [2:0] br, input logic [2:0] fl, input logic fwe,
                            input logic [31:0] res, input logic [31:0] tgt,
                            input logic [31:0] pc4, input logic [4:0] rd, input logic rwe);
    bus.br_type    = br;
    bus.alu_flag   = fl;
    bus.flag_we    = fwe;
    bus.alu_result = res;
    bus.br_target  = tgt;
    bus.pc_plus4   = pc4;
    bus.rd_addr    = rd;
    bus.rd_we      = rwe;
  endtask

  // Presents one packet, waits (bounded) for acceptance, returns whether it should emit.
  task automatic drive(input logic [2:0] br, input logic [2:0] fl, input logic fwe,
                       input logic [31:0] res, input logic [31:0] tgt, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rwe, output logic live);
    int n = 0;
    set_inputs(br, fl, fwe, res, tgt, pc4, rd, rwe);
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    model_accept(live);
    bus.in_valid = 1'b0;
  endtask

  task automatic model_reset();
    model_flags  = 3'b000;
    model_squash = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic live;
    logic [70:0] exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, pkt, bus.flags_q} !== 75'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h required 0", {bus.out_valid, pkt, bus.flags_q});
    end
    rst = 1'b0;
    model_reset();
    // Build up a held packet plus a pending squash, then reset mid-cycle.
    drive(3'd3, 3'b010, 1'b1, 32'h9, 32'h300, 32'h30, 5'd4, 1'b1, live);
    void'(sb.pop_front());
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_valid: got %b required 1", bus.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, pkt, bus.flags_q} !== 75'd0) begin
      errors++;
      $display("[TB] FAIL midstream_reset: got %h required 0", {bus.out_valid, pkt, bus.flags_q});
    end
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    drive(3'd0, 3'b000, 1'b0, 32'h1234, 32'h0, 32'h8, 5'd5, 1'b1, live);
    checks++;
    if (bus.out_valid !== 1'b1 || !live) begin
      errors++;
      $display("[TB] FAIL post_reset_valid: got %b required 1", bus.out_valid);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (pkt !== exp || pkt[70:39] !== 32'h1234 || pkt[38:34] !== 5'd5 || pkt[33] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL post_reset_pkt: got %h required %h", pkt, exp);
      end
    end
  endtask

  task automatic test_branch_squash();
    logic live;
    logic [70:0] exp;
    drive(3'd3, 3'b010, 1'b0, 32'h5, 32'h100, 32'h44, 5'd3, 1'b0, live);
    exp = sb.pop_front();
    checks++;
    if (pkt !== exp || bus.branch_taken !== 1'b1 || bus.next_pc !== 32'h100) begin
      errors++;
      $display("[TB] FAIL bz_taken: got %h required %h", pkt, exp);
    end
    drive(3'd0, 3'b111, 1'b1, 32'hAA, 32'h0, 32'h48, 5'd6, 1'b1, live);
    checks++;
    if (bus.out_valid !== 1'b0 || live) begin
      errors++;
      $display("[TB] FAIL squash_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (bus.flags_q !== model_flags) begin
      errors++;
      $display("[TB] FAIL squash_flags: got %b required %b", bus.flags_q, model_flags);
    end
    drive(3'd0, 3'b000, 1'b0, 32'hBB, 32'h0, 32'h4C, 5'd7, 1'b1, live);
    checks++;
    if (bus.out_valid !== 1'b1 || !live) begin
      errors++;
      $display("[TB] FAIL after_squash_valid: got %b required 1", bus.out_valid);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (pkt !== exp) begin
        errors++;
        $display("[TB] FAIL after_squash_pkt: got %h required %h", pkt, exp);
      end
    end
  endtask

  task automatic test_carry();
    logic live;
    logic [70:0] exp;
    drive(3'd0, 3'b001, 1'b1, 32'h7, 32'h0, 32'h10, 5'd2, 1'b1, live);
    void'(sb.pop_front());
    drive(3'd5, 3'b000, 1'b0, 32'h0, 32'h200, 32'h14, 5'd0, 1'b0, live);
    exp = sb.pop_front();
    checks++;
    if (pkt !== exp || bus.branch_taken !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bcy_taken: got %h required %h", pkt, exp);
    end
    drive(3'd0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h18, 5'd0, 1'b0, live);
    drive(3'd6, 3'b000, 1'b1, 32'h0, 32'h240, 32'h1C, 5'd0, 1'b0, live);
    exp = sb.pop_front();
    checks++;
    if (pkt !== exp || bus.branch_taken !== 1'b0 || bus.next_pc !== 32'h1C) begin
      errors++;
      $display("[TB] FAIL bncy_not_taken: got %h required %h", pkt, exp);
    end
    checks++;
    if (bus.flags_q !== 3'b000) begin
      errors++;
      $display("[TB] FAIL bncy_flags: got %b required 000", bus.flags_q);
    end
  endtask

  task automatic test_bl();
    logic live;
    logic [70:0] exp;
    drive(3'd7, 3'b000, 1'b0, 32'h55, 32'h80, 32'h2C, 5'd9, 1'b0, live);
    exp = sb.pop_front();
    checks++;
    if (pkt !== exp || pkt !== {32'h2C, 5'd31, 1'b1, 1'b1, 32'h80}) begin
      errors++;
      $display("[TB] FAIL bl_link: got %h required %h", pkt, exp);
    end
    drive(3'd0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h84, 5'd0, 1'b0, live);
  endtask

  task automatic test_back_to_back();
    logic live;
    logic [70:0] held;
    logic [70:0] exp;
    drive(3'd0, 3'b100, 1'b0, 32'hCAFE, 32'h0, 32'h60, 5'd10, 1'b1, live);
    held = sb.pop_front();
    bus.out_ready = 1'b0;
    set_inputs(3'd0, 3'b000, 1'b0, 32'hBEEF, 32'h0, 32'h64, 5'd11, 1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || pkt !== held) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got rdy=%b vld=%b %h required 0 1 %h",
                 i, bus.in_ready, bus.out_valid, pkt, held);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    model_accept(live);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || !live) begin
      errors++;
      $display("[TB] FAIL stall_release_valid: got %b required 1", bus.out_valid);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (pkt !== exp) begin
        errors++;
        $display("[TB] FAIL stall_release_pkt: got %h required %h", pkt, exp);
      end
    end
  endtask

  task automatic test_r0_bnz();
    logic live;
    logic [70:0] exp;
    drive(3'd0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h70, 5'd0, 1'b1, live);
    exp = sb.pop_front();
    checks++;
    if (pkt !== exp || bus.wb_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r0_suppress: got %h required %h", pkt, exp);
    end
    drive(3'd4, 3'b010, 1'b0, 32'h1, 32'h400, 32'h74, 5'd12, 1'b1, live);
    exp = sb.pop_front();
    checks++;
    if (pkt !== exp || bus.branch_taken !== 1'b0 || bus.next_pc !== 32'h74) begin
      errors++;
      $display("[TB] FAIL bnz_not_taken: got %h required %h", pkt, exp);
    end
    drive(3'd0, 3'b000, 1'b0, 32'h77, 32'h0, 32'h78, 5'd13, 1'b1, live);
    checks++;
    if (bus.out_valid !== 1'b1 || !live) begin
      errors++;
      $display("[TB] FAIL bnz_no_squash: got %b required 1", bus.out_valid);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (pkt !== exp) begin
        errors++;
        $display("[TB] FAIL bnz_follow_pkt: got %h required %h", pkt, exp);
      end
    end
  endtask

  task automatic test_random();
    logic live;
    logic [70:0] exp;
    for (int i = 0; i < 40; i++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            live);
      checks++;
      if (bus.out_valid !== live) begin
        errors++;
        $display("[TB] FAIL rand_valid%0d: got %b required %b", i, bus.out_valid, live);
      end
      if (live && sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        if (pkt !== exp) begin
          errors++;
          $display("[TB] FAIL rand_pkt%0d: got %h required %h", i, pkt, exp);
        end
      end
      checks++;
      if (bus.flags_q !== model_flags) begin
        errors++;
        $display("[TB] FAIL rand_flags%0d: got %b required %b", i, bus.flags_q, model_flags);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_inputs(3'd0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    model_reset();
    test_reset();
    test_branch_squash();
    test_carry();
    test_bl();
    test_back_to_back();
    test_r0_bnz();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Execute-stage back end. Sits directly downstream of the 32-bit ALU.
- Consumes the ALU result and its 3-bit flag vector {sign, zero, carry}.
- Holds the architectural flag register, resolves conditional branches, squashes wrong-path slots and registers the writeback packet for the register file.
- Valid/ready on both sides. Single registered output entry; latency 1 cycle.

Parameters:
- FLUSH_SLOTS, 1: accepted inputs discarded after a taken branch. Legal range 0..7; 0 disables squash.
- LINK_REG, 31: destination register index written by bl.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream packet valid
- in_ready  out  1  unit can accept
- alu_result  in  32  ALU result
- alu_flag  in  3  [2] sign, [1] zero, [0] carry of the current op
- flag_we  in  1  latch alu_flag into flag register on accept
- br_type  in  3  000 none, 001 b, 010 bltz, 011 bz, 100 bnz, 101 bcy, 110 bncy, 111 bl
- br_target  in  32  branch target address
- pc_plus4  in  32  sequential next PC
- rd_addr  in  5  destination register
- rd_we  in  1  instruction writes rd
- out_valid  out  1  writeback packet valid
- out_ready  in  1  downstream accepts
- wb_data  out  32  writeback data
- wb_addr  out  5  writeback register
- wb_en  out  1  perform register write
- branch_taken  out  1  redirect fetch; meaningful only with out_valid
- next_pc  out  32  br_target if taken, else pc_plus4
- flags_q  out  3  architectural flag register

Behaviour:
- Reset: async on rst high.
  - out_valid=0, wb_data=0, wb_addr=0, wb_en=0, branch_taken=0, next_pc=0, flags_q=3'b000.
  - Squash counter=0; state=RUN.
- Reset mid-operation drops any held or pending packet and any pending squash.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - Accept occurs when in_valid && in_ready.
  - While out_valid && !out_ready, all outputs hold stable.
  - out_valid clears on an out_ready cycle with no new non-squashed accept.
- Branch condition, evaluated at accept:
  - b, bl: always taken.
  - bltz: taken when alu_flag[2]=1. bz: taken when alu_flag[1]=1. bnz: taken when alu_flag[1]=0.
  - bcy: taken when flags_q[0]=1. bncy: taken when flags_q[0]=0.
  - bcy/bncy use flags_q before any update by the same packet.
  - none: never taken.
- Flag register: on a non-squashed accept with flag_we=1, flags_q <= alu_flag at the next edge.
- Writeback:
  - bl: wb_data=pc_plus4, wb_addr=LINK_REG, wb_en=1.
  - Otherwise: wb_data=alu_result, wb_addr=rd_addr, wb_en=rd_we && (rd_addr!=0).
  - Writes to r0 are always suppressed.
- Output registration: the non-squashed accept at edge N produces out_valid=1 with its packet from edge N onward.
- State machine:
  - RUN: normal processing. On accept of a taken branch, if FLUSH_SLOTS>0, go to SQUASH with cnt=FLUSH_SLOTS.
  - SQUASH: each accept is consumed and discarded: no flag update, no output, branch field ignored. cnt decrements per accept. When cnt reaches 0 on an accept, return to RUN.
  - No accept, no change.
- in_ready in SQUASH follows the same formula. A held output still blocks intake.
- With FLUSH_SLOTS=0, state is permanently RUN.
- Squash counter width is 3 bits; FLUSH_SLOTS>7 is illegal.
- No arithmetic beyond comparison. PC values pass through unmodified; no wrap handling required.

Test Plan:
- Reset asserted mid-stream with out_valid=1 and SQUASH pending -> all outputs zero immediately; after release, the first accept of rd_addr=5, alu_result=32'h1234, rd_we=1 gives wb_addr=5, wb_data=32'h1234, wb_en=1 one edge later.
- bz with alu_flag=3'b010, br_target=32'h100, pc_plus4=32'h44 -> branch_taken=1, next_pc=32'h100. Next accepted packet (rd_we=1) squashed: no out_valid, flags_q unchanged even with flag_we=1. Following packet emitted.
- Add with flag_we=1, alu_flag=3'b001, then bcy -> taken. Then bncy with flag_we=1, alu_flag=3'b000 -> not taken (uses old carry=1); flags_q becomes 000 afterwards.
- bl with pc_plus4=32'h2C, br_target=32'h80 -> wb_addr=31, wb_data=32'h2C, wb_en=1, next_pc=32'h80.
- out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0, outputs stable. out_ready=1 -> new packet accepted that edge, out_valid stays 1 with new data.
- rd_addr=0, rd_we=1, alu_result=32'hFFFFFFFF -> wb_en=0. bnz with alu_flag[1]=1 -> not taken, next_pc=pc_plus4, no squash.
